// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register of the 19-bit CPU, with forwarding and an iterative multiplier.
// Define EX_DIV_EN to add the iterative restoring divider for opcode 8; otherwise opcode 8 yields 0.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  EX_opcode,
  input  logic        EX_regwrite,
  input  logic        EX_memtoreg,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic        EX_alusrc,
  input  logic        EX_aluop,
  input  logic        EX_regdist,
  input  logic [7:0]  EX_immediate,
  input  logic [2:0]  EX_rs,
  input  logic [2:0]  EX_rt,
  input  logic [2:0]  EX_rd,
  input  logic [31:0] EX_rd1,
  input  logic [31:0] EX_rd2,
  input  logic        WB_regwrite,
  input  logic [2:0]  WB_rd_dest,
  input  logic [31:0] WB_result,
  output logic        ex_stall,
  output logic        MEM_regwrite,
  output logic        MEM_memtoreg,
  output logic        MEM_memread,
  output logic        MEM_memwrite,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_store_data,
  output logic [2:0]  MEM_rd_dest
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_SRL = 5'd6;
  localparam logic [4:0] OP_MUL = 5'd7;
  localparam logic [4:0] OP_DIV = 5'd8;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic        mem_regwrite_q, mem_regwrite_d, mem_memtoreg_q, mem_memtoreg_d;
  logic        mem_memread_q, mem_memread_d, mem_memwrite_q, mem_memwrite_d;
  logic [31:0] mem_alu_result_q, mem_alu_result_d, mem_store_data_q, mem_store_data_d;
  logic [2:0]  mem_rd_dest_q, mem_rd_dest_d;

  logic [31:0] fwd_a, fwd_b, op_b, alu_res, multi_res, mul_acc;
  logic [4:0]  alu_op;
  logic        is_mul, is_div, multi_op, stall;
`ifdef EX_DIV_EN
  logic        is_div_q, is_div_d;
  logic [32:0] rem_sh;
  logic        rem_ge;
`endif

  // Forwarding, operand selection, single-cycle ALU and iteration step datapath
  always_comb begin
    if (mem_regwrite_q && (mem_rd_dest_q == EX_rs)) begin
      fwd_a = mem_alu_result_q;
    end else if (WB_regwrite && (WB_rd_dest == EX_rs)) begin
      fwd_a = WB_result;
    end else begin
      fwd_a = EX_rd1;
    end
    if (mem_regwrite_q && (mem_rd_dest_q == EX_rt)) begin
      fwd_b = mem_alu_result_q;
    end else if (WB_regwrite && (WB_rd_dest == EX_rt)) begin
      fwd_b = WB_result;
    end else begin
      fwd_b = EX_rd2;
    end
    op_b   = EX_alusrc ? {24'd0, EX_immediate} : fwd_b;
    alu_op = EX_aluop ? EX_opcode : OP_ADD;
    is_mul = EX_aluop && (EX_opcode == OP_MUL);
`ifdef EX_DIV_EN
    is_div = EX_aluop && (EX_opcode == OP_DIV);
    rem_sh = {acc_q, a_q[31]};
    rem_ge = (rem_sh >= {1'b0, b_q});
    multi_res = is_div_q ? a_q : acc_q;
`else
    is_div = 1'b0;
    multi_res = acc_q;
`endif
    multi_op = is_mul || is_div;
    mul_acc  = b_q[0] ? (acc_q + a_q) : acc_q;
    case (alu_op)
      OP_ADD:  alu_res = fwd_a + op_b;
      OP_SUB:  alu_res = fwd_a - op_b;
      OP_AND:  alu_res = fwd_a & op_b;
      OP_OR:   alu_res = fwd_a | op_b;
      OP_XOR:  alu_res = fwd_a ^ op_b;
      OP_SLL:  alu_res = fwd_a << op_b[4:0];
      OP_SRL:  alu_res = fwd_a >> op_b[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  assign stall    = ((state_q == IDLE) && multi_op) || (state_q == BUSY);
  assign ex_stall = !rst && stall;

  // Multi-cycle FSM next state and EX/MEM register next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
`ifdef EX_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      IDLE: begin
        if (multi_op) begin
          state_d = BUSY;
          cnt_d   = 5'd31;
          a_d     = fwd_a;
          b_d     = op_b;
          acc_d   = 32'd0;
`ifdef EX_DIV_EN
          is_div_d = is_div;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef EX_DIV_EN
        if (is_div_q) begin
          acc_d = rem_ge ? (rem_sh[31:0] - b_q) : rem_sh[31:0];
          a_d   = {a_q[30:0], rem_ge};
        end else begin
`else
        begin
`endif
          acc_d = mul_acc;
          a_d   = {a_q[30:0], 1'b0};
          b_d   = {1'b0, b_q[31:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_alu_result_d = mem_alu_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_dest_d    = mem_rd_dest_q;
    if (stall) begin
      mem_regwrite_d = 1'b0;
      mem_memtoreg_d = 1'b0;
      mem_memread_d  = 1'b0;
      mem_memwrite_d = 1'b0;
    end else begin
      mem_regwrite_d   = EX_regwrite;
      mem_memtoreg_d   = EX_memtoreg;
      mem_memread_d    = EX_memread;
      mem_memwrite_d   = EX_memwrite;
      mem_alu_result_d = (state_q == DONE) ? multi_res : alu_res;
      mem_store_data_d = fwd_b;
      mem_rd_dest_d    = EX_regdist ? EX_rd : EX_rt;
    end
  end

  // State registers; reset also aborts any multiply/divide in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 5'd0;
      a_q              <= 32'd0;
      b_q              <= 32'd0;
      acc_q            <= 32'd0;
`ifdef EX_DIV_EN
      is_div_q         <= 1'b0;
`endif
      mem_regwrite_q   <= 1'b0;
      mem_memtoreg_q   <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_alu_result_q <= 32'd0;
      mem_store_data_q <= 32'd0;
      mem_rd_dest_q    <= 3'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      a_q              <= a_d;
      b_q              <= b_d;
      acc_q            <= acc_d;
`ifdef EX_DIV_EN
      is_div_q         <= is_div_d;
`endif
      mem_regwrite_q   <= mem_regwrite_d;
      mem_memtoreg_q   <= mem_memtoreg_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_dest_q    <= mem_rd_dest_d;
    end
  end

  assign MEM_regwrite   = mem_regwrite_q;
  assign MEM_memtoreg   = mem_memtoreg_q;
  assign MEM_memread    = mem_memread_q;
  assign MEM_memwrite   = mem_memwrite_q;
  assign MEM_alu_result = mem_alu_result_q;
  assign MEM_store_data = mem_store_data_q;
  assign MEM_rd_dest    = mem_rd_dest_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for single-cycle ops and forwarding,
// hand sequences for MUL/DIV stall timing, back-to-back issue and reset abort.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  EX_opcode;
  logic        EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite;
  logic        EX_alusrc, EX_aluop, EX_regdist;
  logic [7:0]  EX_immediate;
  logic [2:0]  EX_rs, EX_rt, EX_rd;
  logic [31:0] EX_rd1, EX_rd2;
  logic        WB_regwrite;
  logic [2:0]  WB_rd_dest;
  logic [31:0] WB_result;
  logic        ex_stall;
  logic        MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
  logic [31:0] MEM_alu_result, MEM_store_data;
  logic [2:0]  MEM_rd_dest;

  ex_mem_stage dut (
    .clk(clk), .rst(rst),
    .EX_opcode(EX_opcode), .EX_regwrite(EX_regwrite), .EX_memtoreg(EX_memtoreg),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite), .EX_alusrc(EX_alusrc),
    .EX_aluop(EX_aluop), .EX_regdist(EX_regdist), .EX_immediate(EX_immediate),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_rd1(EX_rd1), .EX_rd2(EX_rd2),
    .WB_regwrite(WB_regwrite), .WB_rd_dest(WB_rd_dest), .WB_result(WB_result),
    .ex_stall(ex_stall), .MEM_regwrite(MEM_regwrite), .MEM_memtoreg(MEM_memtoreg),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .MEM_alu_result(MEM_alu_result), .MEM_store_data(MEM_store_data),
    .MEM_rd_dest(MEM_rd_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        aluop, alusrc, regdist;
    logic [7:0]  imm;
    logic [2:0]  rs, rt, rd;
    logic [31:0] rd1, rd2;
    logic [3:0]  ctl;   // {regwrite, memtoreg, memread, memwrite}
    logic        wbw;
    logic [2:0]  wbrd;
    logic [31:0] wbres, exp_res, exp_store;
    logic [2:0]  exp_dest;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [4:0] op, input logic aluop, alusrc, regdist,
                              input logic [7:0] imm, input logic [2:0] rs, rt, rd,
                              input logic [31:0] rd1, rd2, input logic [3:0] ctl,
                              input logic wbw, input logic [2:0] wbrd, input logic [31:0] wbres,
                              input logic [31:0] exp_res, exp_store, input logic [2:0] exp_dest);
    vec_t v;
    v.op = op; v.aluop = aluop; v.alusrc = alusrc; v.regdist = regdist; v.imm = imm;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2; v.ctl = ctl;
    v.wbw = wbw; v.wbrd = wbrd; v.wbres = wbres;
    v.exp_res = exp_res; v.exp_store = exp_store; v.exp_dest = exp_dest;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    EX_opcode = v.op; EX_aluop = v.aluop; EX_alusrc = v.alusrc; EX_regdist = v.regdist;
    EX_immediate = v.imm; EX_rs = v.rs; EX_rt = v.rt; EX_rd = v.rd;
    EX_rd1 = v.rd1; EX_rd2 = v.rd2;
    {EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite} = v.ctl;
    WB_regwrite = v.wbw; WB_rd_dest = v.wbrd; WB_result = v.wbres;
  endtask

  function automatic logic [3:0] mem_ctl();
    return {MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite};
  endfunction

  task automatic nop_cycle();
    drive(mk(5'd0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 3'd0, 3'd0, 32'd0, 32'd0, 4'b0000,
             1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0));
    @(posedge clk); #1;
  endtask

  // Issue a MUL/DIV (rs=2, rt=3, dest 4) and check stall length, bubbles and result
  task automatic run_multi(input string name, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int stalls = 0;
    logic bubble_ok = 1'b1;
    nop_cycle();
    drive(mk(op, 1'b1, 1'b0, 1'b1, 8'd0, 3'd2, 3'd3, 3'd4, a, b, 4'b1000,
             1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ex_stall) break;
      stalls++;
      @(posedge clk); #1;
      if (mem_ctl() != 4'b0000) bubble_ok = 1'b0;
    end
    chk({name, " stall cycles"}, stalls, 32'd33);
    chk({name, " bubble ctl"}, {31'd0, bubble_ok}, 32'd1);
    @(posedge clk); #1;
    chk({name, " result"}, MEM_alu_result, exp);
    chk({name, " ctl"}, {28'd0, mem_ctl()}, 32'h8);
    chk({name, " dest"}, {29'd0, MEM_rd_dest}, 32'd4);
  endtask

  initial begin
    // op, aluop, alusrc, regdist, imm, rs, rt, rd, rd1, rd2, ctl, wbw, wbrd, wbres, exp_res, exp_store, exp_dest
    vecs.push_back(mk(5'd0, 1'b1, 1'b0, 1'b1, 8'd0, 3'd1, 3'd2, 3'd1, 32'd3, 32'd4, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd7, 32'd4, 3'd1));
    vecs.push_back(mk(5'd0, 1'b1, 1'b0, 1'b1, 8'd0, 3'd3, 3'd4, 3'd1, 32'd2, 32'd3, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd5, 32'd3, 3'd1));
    vecs.push_back(mk(5'd1, 1'b1, 1'b0, 1'b1, 8'd0, 3'd1, 3'd1, 3'd2, 32'd0, 32'd0, 4'b0000, 1'b1, 3'd1, 32'd9, 32'd0, 32'd5, 3'd2));
    vecs.push_back(mk(5'd0, 1'b1, 1'b1, 1'b1, 8'd1, 3'd1, 3'd1, 3'd3, 32'd0, 32'd0, 4'b1000, 1'b1, 3'd1, 32'd9, 32'd10, 32'd9, 3'd3));
    vecs.push_back(mk(5'd9, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd5, 3'd6, 3'd2, 32'h100, 32'hABC, 4'b1100, 1'b0, 3'd0, 32'd0, 32'h1FF, 32'hABC, 3'd6));
    vecs.push_back(mk(5'd2, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd0, 32'hF0F0, 32'hFF00, 4'b0010, 1'b0, 3'd0, 32'd0, 32'hF000, 32'hFF00, 3'd0));
    vecs.push_back(mk(5'd3, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd0, 32'hF0F0, 32'hFF00, 4'b1000, 1'b0, 3'd0, 32'd0, 32'hFFF0, 32'hFF00, 3'd0));
    vecs.push_back(mk(5'd4, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd1, 32'hF0F0, 32'hFF00, 4'b0001, 1'b0, 3'd0, 32'd0, 32'h00F0, 32'hFF00, 3'd1));
    vecs.push_back(mk(5'd5, 1'b1, 1'b1, 1'b1, 8'h24, 3'd0, 3'd7, 3'd1, 32'd1, 32'd5, 4'b0000, 1'b0, 3'd0, 32'd0, 32'h10, 32'd5, 3'd1));
    vecs.push_back(mk(5'd6, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd1, 32'h80000000, 32'h1F, 4'b0000, 1'b0, 3'd0, 32'd0, 32'd1, 32'h1F, 3'd1));
    vecs.push_back(mk(5'd1, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd1, 32'd0, 32'd1, 4'b0000, 1'b0, 3'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 3'd1));
    vecs.push_back(mk(5'd12, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 3'd7, 3'd1, 32'd5, 32'd6, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd0, 32'd6, 3'd1));
    vecs.push_back(mk(5'd7, 1'b0, 1'b0, 1'b1, 8'd0, 3'd2, 3'd3, 3'd4, 32'd6, 32'd7, 4'b0000, 1'b0, 3'd0, 32'd0, 32'd13, 32'd7, 3'd4));
`ifndef EX_DIV_EN
    vecs.push_back(mk(5'd8, 1'b1, 1'b0, 1'b1, 8'd0, 3'd2, 3'd3, 3'd5, 32'd100, 32'd7, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd0, 32'd7, 3'd5));
`endif

    rst = 1'b1;
    drive(vecs[0]);
    EX_aluop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", {31'd0, ex_stall}, 32'd0);
    chk("reset ctl", {28'd0, mem_ctl()}, 32'd0);
    chk("reset result", MEM_alu_result, 32'd0);
    chk("reset store", MEM_store_data, 32'd0);
    chk("reset dest", {29'd0, MEM_rd_dest}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), {31'd0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d result", i), MEM_alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d store", i), MEM_store_data, vecs[i].exp_store);
      chk($sformatf("vec%0d dest", i), {29'd0, MEM_rd_dest}, {29'd0, vecs[i].exp_dest});
      chk($sformatf("vec%0d ctl", i), {28'd0, mem_ctl()}, {28'd0, vecs[i].ctl});
    end

    run_multi("mul", 5'd7, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    // ADD issued right after DONE, forwarding the MUL result from r4
    drive(mk(5'd0, 1'b1, 1'b1, 1'b1, 8'd1, 3'd4, 3'd3, 3'd5, 32'd0, 32'd0, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0));
    @(negedge clk);
    chk("b2b stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    chk("b2b result", MEM_alu_result, 32'h0005_0010);
    chk("b2b dest", {29'd0, MEM_rd_dest}, 32'd5);

`ifdef EX_DIV_EN
    run_multi("div", 5'd8, 32'd100, 32'd7, 32'd14);
    run_multi("div0", 5'd8, 32'd5, 32'd0, 32'hFFFFFFFF);
`endif

    // Abort a MUL at counter 10 with reset
    nop_cycle();
    drive(mk(5'd7, 1'b1, 1'b0, 1'b1, 8'd0, 3'd2, 3'd3, 3'd4, 32'd9, 32'd9, 4'b1000, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0));
    repeat (22) @(posedge clk);
    #1;
    chk("abort busy stall", {31'd0, ex_stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort stall", {31'd0, ex_stall}, 32'd0);
    chk("abort ctl", {28'd0, mem_ctl()}, 32'd0);
    chk("abort result", MEM_alu_result, 32'd0);
    chk("abort store", MEM_store_data, 32'd0);
    chk("abort dest", {29'd0, MEM_rd_dest}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    chk("post-abort stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    chk("post-abort result", MEM_alu_result, 32'd7);
    chk("post-abort ctl", {28'd0, mem_ctl()}, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
